// File: rtl/coin_change_dispenser.sv
// Coin-return stage: pays a latched balance out greedily, highest denomination
// first, one coin per hopper handshake, tracking per-denomination stock.
module coin_change_dispenser #(
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000,
    parameter int BAL_W      = 31,
    parameter int STOCK_W    = 8,
    parameter int STOCK_INIT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [BAL_W-1:0] i_balance,
    input  logic             i_ready,
    input  logic             i_refill,
    output logic [2:0]       o_return_coin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BAL_W-1:0] o_remaining,
    output logic [2:0]       o_empty
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    localparam logic [BAL_W-1:0]   VAL0      = BAL_W'(COIN0_VAL);
    localparam logic [BAL_W-1:0]   VAL1      = BAL_W'(COIN1_VAL);
    localparam logic [BAL_W-1:0]   VAL2      = BAL_W'(COIN2_VAL);
    localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(STOCK_INIT);

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   rem_q, rem_d;
    logic [BAL_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         sel_q, sel_d;
    logic [STOCK_W-1:0] stock_q [3];
    logic [STOCK_W-1:0] stock_d [3];

    logic               pickFound;
    logic [1:0]         pick;
    logic [BAL_W-1:0]   selVal;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            remaining_q <= '0;
            sel_q       <= '0;
            for (int k = 0; k < 3; k++) begin
                stock_q[k] <= STOCK_RST;
            end
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            remaining_q <= remaining_d;
            sel_q       <= sel_d;
            for (int k = 0; k < 3; k++) begin
                stock_q[k] <= stock_d[k];
            end
        end
    end

    // Later matches override earlier ones, so the highest payable coin wins.
    always_comb begin
        pickFound = 1'b0;
        pick      = 2'd0;
        if (stock_q[0] != '0 && VAL0 <= rem_q) begin
            pickFound = 1'b1;
            pick      = 2'd0;
        end
        if (stock_q[1] != '0 && VAL1 <= rem_q) begin
            pickFound = 1'b1;
            pick      = 2'd1;
        end
        if (stock_q[2] != '0 && VAL2 <= rem_q) begin
            pickFound = 1'b1;
            pick      = 2'd2;
        end
    end

    always_comb begin
        case (sel_q)
            2'd2:    selVal = VAL2;
            2'd1:    selVal = VAL1;
            default: selVal = VAL0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        remaining_d = remaining_q;
        sel_d       = sel_q;
        for (int k = 0; k < 3; k++) begin
            stock_d[k] = stock_q[k];
        end
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rem_d   = i_balance;
                    state_d = (i_balance == '0) ? DONE : SELECT;
                end
            end
            SELECT: begin
                if (pickFound) begin
                    sel_d   = pick;
                    state_d = ISSUE;
                end else begin
                    state_d = DONE;
                end
            end
            ISSUE: begin
                if (i_ready) begin
                    rem_d = rem_q - selVal;
                    for (int k = 0; k < 3; k++) begin
                        if (sel_q == 2'(k)) begin
                            stock_d[k] = stock_q[k] - 1'b1;
                        end
                    end
                    state_d = SELECT;
                end
            end
            DONE: begin
                remaining_d = rem_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Refill overrides any decrement landing on the same edge.
        if (i_refill) begin
            for (int k = 0; k < 3; k++) begin
                stock_d[k] = STOCK_RST;
            end
        end
    end

    always_comb begin
        o_return_coin = (state_q == ISSUE) ? (3'b001 << sel_q) : 3'b000;
        o_busy        = (state_q != IDLE);
        o_done        = (state_q == DONE);
        o_remaining   = remaining_q;
        for (int k = 0; k < 3; k++) begin
            o_empty[k] = (stock_q[k] == '0);
        end
    end

endmodule
